// File: rtl/ghash_pkg.sv
// Shared constants, types and helpers for the multi-context GHASH core.
package ghash_pkg;

    localparam int NB_BLOCK = 128;

    // Reflected reduction constant: x^0, x^1, x^2, x^7 in GCM bit order.
    localparam logic [NB_BLOCK-1:0] GHASH_R = {8'hE1, 120'h0};

    localparam int NB_CTX_DEF = 2;
    typedef logic [NB_CTX_DEF-1:0] ctx_id_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [NB_BLOCK-1:0] rev128(input logic [NB_BLOCK-1:0] v);
        logic [NB_BLOCK-1:0] r;
        for (int i = 0; i < NB_BLOCK; i++) r[i] = v[NB_BLOCK-1-i];
        return r;
    endfunction

endpackage

// File: rtl/gf128_mult_pipe.sv
// Pipelined GF(2^128) multiplier (GCM bit order) with a side-band tag/valid
// delayed by exactly MULT_LAT cycles.
module gf128_mult_pipe
    import ghash_pkg::*;
#(
    parameter int MULT_LAT = 3,
    parameter int TAG_W    = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                vld_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [NB_BLOCK-1:0] a_i,
    input  logic [NB_BLOCK-1:0] b_i,
    output logic                vld_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [NB_BLOCK-1:0] prod_o
);

    localparam logic [NB_BLOCK-1:0] POLY_LO = rev128(GHASH_R);

    function automatic logic [126:0] clmul64(input logic [63:0] a, input logic [63:0] b);
        logic [126:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) r = r ^ ({63'b0, a} << i);
        end
        return r;
    endfunction

    // Fold degrees 254..128 back using x^128 = x^7 + x^2 + x + 1.
    function automatic logic [NB_BLOCK-1:0] reduce255(input logic [254:0] p);
        logic [254:0] t;
        logic [254:0] pf;
        t  = p;
        pf = {126'b0, 1'b1, POLY_LO};
        for (int i = 254; i >= 128; i--) begin
            if (t[i]) t = t ^ (pf << (i - 128));
        end
        return t[NB_BLOCK-1:0];
    endfunction

    logic [NB_BLOCK-1:0] an, bn;
    logic [126:0]        hh_d, ll_d, mm_d;
    logic [126:0]        hh_q, ll_q, mm_q;
    logic                vld_q;
    logic [TAG_W-1:0]    tag_q;
    logic [126:0]        mid;
    logic [254:0]        full;
    logic [NB_BLOCK-1:0] prod_s1;

    // Stage 0: Karatsuba partial products in polynomial (non-reflected) order
    assign an   = rev128(a_i);
    assign bn   = rev128(b_i);
    assign hh_d = clmul64(an[127:64], bn[127:64]);
    assign ll_d = clmul64(an[63:0], bn[63:0]);
    assign mm_d = clmul64(an[127:64] ^ an[63:0], bn[127:64] ^ bn[63:0]);

    always_ff @(posedge clk_i) begin
        hh_q <= hh_d;
        ll_q <= ll_d;
        mm_q <= mm_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_i;
            tag_q <= tag_i;
        end
    end

    // Stage 1: recombine and reduce
    assign mid     = mm_q ^ hh_q ^ ll_q;
    assign full    = {hh_q, 128'b0} ^ {64'b0, mid, 64'b0} ^ {128'b0, ll_q};
    assign prod_s1 = rev128(reduce255(full));

    generate
        if (MULT_LAT == 1) begin : g_lat1
            assign vld_o  = vld_q;
            assign tag_o  = tag_q;
            assign prod_o = prod_s1;
        end else begin : g_latn
            localparam int ND = MULT_LAT - 1;
            logic [NB_BLOCK-1:0] prod_dq [ND];
            logic [TAG_W-1:0]    tag_dq  [ND];
            logic [ND-1:0]       vld_dq;

            always_ff @(posedge clk_i) begin
                prod_dq[0] <= prod_s1;
                for (int k = 1; k < ND; k++) prod_dq[k] <= prod_dq[k-1];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_dq <= '0;
                    for (int k = 0; k < ND; k++) tag_dq[k] <= '0;
                end else begin
                    vld_dq[0] <= vld_q;
                    tag_dq[0] <= tag_q;
                    for (int k = 1; k < ND; k++) begin
                        vld_dq[k] <= vld_dq[k-1];
                        tag_dq[k] <= tag_dq[k-1];
                    end
                end
            end

            assign vld_o  = vld_dq[ND-1];
            assign tag_o  = tag_dq[ND-1];
            assign prod_o = prod_dq[ND-1];
        end
    endgenerate

endmodule

// File: rtl/ghash_core_mctx_pipe.sv
// Multi-context GHASH accumulator sharing one pipelined GF(2^128) multiplier.
// Optional per-context key storage: GHASH_CORE_MCTX_KEY_PER_CTX_EN.
module ghash_core_mctx_pipe
    import ghash_pkg::*;
#(
    parameter int NB_DATA  = 128,
    parameter int N_CTX    = 4,
    parameter int NB_CTX   = 2,
    parameter int MULT_LAT = 3
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTX-1:0]  i_ctx,
    input  logic               i_sop,
    input  logic               i_eop,
    input  logic [NB_DATA-1:0] i_data_x,
    input  logic [NB_DATA-1:0] i_h_key,
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
    input  logic               i_key_load,
    input  logic [NB_CTX-1:0]  i_key_ctx,
`endif
    output logic               o_valid,
    output logic [NB_CTX-1:0]  o_ctx,
    output logic [NB_DATA-1:0] o_data_y,
    output logic [N_CTX-1:0]   o_busy
);

    localparam logic BAD_CONF = (NB_DATA != NB_BLOCK) || (N_CTX < 1) ||
                                (NB_CTX != clog2(N_CTX)) || (MULT_LAT < 1);
    localparam int   TAG_W    = NB_CTX + 1;

    logic [N_CTX-1:0]   busy_q, busy_d;
    logic [NB_DATA-1:0] acc_q [N_CTX];
    logic               ctx_ok, busy_sel, accept;
    logic [NB_DATA-1:0] acc_sel, key_sel, operand;
    logic               res_vld;
    logic [TAG_W-1:0]   res_tag;
    logic [NB_DATA-1:0] res_prod;
    logic [NB_CTX-1:0]  res_ctx;
    logic               res_eop;
    logic               o_valid_q;
    logic [NB_CTX-1:0]  o_ctx_q;
    logic [NB_DATA-1:0] o_data_q;

    // Out-of-range ids match no context and are therefore never ready.
    always_comb begin
        ctx_ok   = 1'b0;
        busy_sel = 1'b0;
        acc_sel  = '0;
        for (int c = 0; c < N_CTX; c++) begin
            if (i_ctx == NB_CTX'(c)) begin
                ctx_ok   = 1'b1;
                busy_sel = busy_q[c];
                acc_sel  = acc_q[c];
            end
        end
    end

    assign o_ready = !BAD_CONF && ctx_ok && !busy_sel;
    assign accept  = i_valid && o_ready;
    assign operand = i_data_x ^ (i_sop ? '0 : acc_sel);

`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
    logic [NB_DATA-1:0] key_q [N_CTX];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < N_CTX; c++) key_q[c] <= '0;
        end else if (i_key_load) begin
            for (int c = 0; c < N_CTX; c++) begin
                if (i_key_ctx == NB_CTX'(c)) key_q[c] <= i_h_key;
            end
        end
    end

    always_comb begin
        key_sel = '0;
        for (int c = 0; c < N_CTX; c++) begin
            if (i_ctx == NB_CTX'(c)) key_sel = key_q[c];
        end
    end
`else
    assign key_sel = i_h_key;
`endif

    gf128_mult_pipe #(
        .MULT_LAT (MULT_LAT),
        .TAG_W    (TAG_W)
    ) u_mult (
        .clk_i  (i_clock),
        .rst_ni (i_reset_n),
        .vld_i  (accept),
        .tag_i  ({i_ctx, i_eop}),
        .a_i    (operand),
        .b_i    (key_sel),
        .vld_o  (res_vld),
        .tag_o  (res_tag),
        .prod_o (res_prod)
    );

    assign res_ctx = res_tag[TAG_W-1:1];
    assign res_eop = res_tag[0];

    // Writeback and accept never target the same context in one cycle.
    always_comb begin
        busy_d = busy_q;
        for (int c = 0; c < N_CTX; c++) begin
            if (res_vld && res_ctx == NB_CTX'(c)) busy_d[c] = 1'b0;
            if (accept && i_ctx == NB_CTX'(c))    busy_d[c] = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q    <= '0;
            o_valid_q <= 1'b0;
            o_ctx_q   <= '0;
            o_data_q  <= '0;
            for (int c = 0; c < N_CTX; c++) acc_q[c] <= '0;
        end else begin
            busy_q    <= busy_d;
            o_valid_q <= res_vld && res_eop;
            if (res_vld && res_eop) begin
                o_ctx_q  <= res_ctx;
                o_data_q <= res_prod;
            end
            for (int c = 0; c < N_CTX; c++) begin
                if (res_vld && res_ctx == NB_CTX'(c)) acc_q[c] <= res_prod;
            end
        end
    end

    assign o_valid  = o_valid_q;
    assign o_ctx    = o_ctx_q;
    assign o_data_y = o_data_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_ghash_core_mctx_pipe.sv
// Bench for ghash_core_mctx_pipe: directed message table, corner sequences and
// randomized traffic checked against a bit-serial GF(2^128) reference model.
module tb_ghash_core_mctx_pipe;
    import ghash_pkg::*;

    localparam int NB_DATA = 128;
    localparam int N_CTX   = 4;
    localparam int NB_CTX  = 2;
    localparam int L       = 3;

    localparam logic [127:0] H0   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X1   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] X2   = 128'h00000000000000000000000000000080;
    localparam logic [127:0] Y1   = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] Y2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [127:0] ONE  = 128'h80000000000000000000000000000000;
    localparam logic [127:0] RCON = 128'he1000000000000000000000000000000;

    logic               clk, rst_n, i_valid, o_ready, i_sop, i_eop, o_valid;
    ctx_id_t            i_ctx, o_ctx;
    logic [NB_DATA-1:0] i_data_x, i_h_key, o_data_y;
    logic [N_CTX-1:0]   o_busy;
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
    logic               i_key_load;
    ctx_id_t            i_key_ctx;
`endif

    ghash_core_mctx_pipe #(
        .NB_DATA (NB_DATA), .N_CTX (N_CTX), .NB_CTX (NB_CTX), .MULT_LAT (L)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_ctx     (i_ctx),
        .i_sop     (i_sop),
        .i_eop     (i_eop),
        .i_data_x  (i_data_x),
        .i_h_key   (i_h_key),
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
        .i_key_load(i_key_load),
        .i_key_ctx (i_key_ctx),
`endif
        .o_valid   (o_valid),
        .o_ctx     (o_ctx),
        .o_data_y  (o_data_y),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // Multiplication exactly as the GCM standard defines it (shift right, xor R).
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ RCON) : (v >> 1);
        end
        return z;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct { int due; ctx_id_t ctx; logic [127:0] y; } res_t;
    res_t         exp_q[$];
    res_t         obs_q[$];
    logic [127:0] m_acc  [N_CTX];
    logic [127:0] m_key  [N_CTX];
    int           m_last [N_CTX];
    ctx_id_t      hold_ctx;
    logic [127:0] hold_y;
    bit           acc_flag;

    function automatic bit m_busy(input int c);
        return (m_last[c] <= edge_n) && (edge_n - m_last[c] < L);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int c = 0; c < N_CTX; c++) begin
            m_acc[c]  = '0;
            m_key[c]  = '0;
            m_last[c] = -1000;
        end
        hold_ctx = '0;
        hold_y   = '0;
        acc_flag = 1'b0;
    endtask

    // Reference model: outputs of the current cycle, then the handshake for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_clear();
            chk("rst_o_valid", 128'(o_valid), 128'(0));
            chk("rst_o_busy", 128'(o_busy), 128'(0));
            chk("rst_o_data_y", o_data_y, 128'(0));
            chk("rst_o_ctx", 128'(o_ctx), 128'(0));
        end else begin
            logic [N_CTX-1:0] eb;
            logic [127:0]     op, key;
            bit               rdy;
            int               c;
            if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
                res_t e;
                e = exp_q.pop_front();
                chk("o_valid_hi", 128'(o_valid), 128'(1));
                chk("o_ctx", 128'(o_ctx), 128'(e.ctx));
                chk("o_data_y", o_data_y, e.y);
                hold_ctx = e.ctx;
                hold_y   = e.y;
            end else begin
                chk("o_valid_lo", 128'(o_valid), 128'(0));
            end
            if (o_valid) obs_q.push_back('{edge_n, o_ctx, o_data_y});
            chk("hold_y", o_data_y, hold_y);
            chk("hold_ctx", 128'(o_ctx), 128'(hold_ctx));
            for (int k = 0; k < N_CTX; k++) eb[k] = m_busy(k);
            chk("o_busy", 128'(o_busy), 128'(eb));
            c   = int'(i_ctx);
            rdy = (c < N_CTX) && !m_busy(c);
            chk("o_ready", 128'(o_ready), 128'(rdy));
            acc_flag = i_valid && rdy;
            if (acc_flag) begin
                op = i_data_x ^ (i_sop ? 128'(0) : m_acc[c]);
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
                key = m_key[c];
`else
                key = i_h_key;
`endif
                m_acc[c]  = gmul(op, key);
                m_last[c] = edge_n + 1;
                if (i_eop) exp_q.push_back('{edge_n + 1 + L, i_ctx, m_acc[c]});
            end
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
            if (i_key_load) m_key[int'(i_key_ctx)] = i_h_key;
`endif
        end
    end

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ctx, input bit sop, input bit eop,
                        input logic [127:0] x, input logic [127:0] h, output int acc_edge);
        bit got;
        got      = 1'b0;
        acc_edge = -1;
        i_valid  = 1'b1;
        i_ctx    = ctx_id_t'(ctx);
        i_sop    = sop;
        i_eop    = eop;
        i_data_x = x;
        i_h_key  = h;
        for (int n = 0; n < 50 && !got; n++) begin
            @(posedge clk);
            #1;
            if (acc_flag) begin
                got      = 1'b1;
                acc_edge = edge_n;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ctx=%0d never accepted", ctx);
        end
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 40 && obs_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("result_count", 128'(obs_q.size()), 128'(n));
    endtask

    task automatic load_key(input int ctx, input logic [127:0] h);
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
        i_valid    = 1'b0;
        i_key_load = 1'b1;
        i_key_ctx  = ctx_id_t'(ctx);
        i_h_key    = h;
        @(posedge clk);
        #1;
        i_key_load = 1'b0;
`else
        i_h_key = h ^ 128'(ctx);
`endif
    endtask

    typedef struct {
        int ctx; bit two; logic [127:0] h; logic [127:0] x1; logic [127:0] x2; logic [127:0] y;
    } msg_t;
    msg_t tbl[6];

    initial begin
        int e0, e1, ea[8];
        rst_n = 1'b0;
        i_valid = 1'b0; i_ctx = '0; i_sop = 1'b0; i_eop = 1'b0;
        i_data_x = '0; i_h_key = '0;
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
        i_key_load = 1'b0; i_key_ctx = '0;
`endif
        model_clear();
        tbl[0] = '{0, 1'b0, H0,   X1,  '0, Y1};
        tbl[1] = '{0, 1'b1, H0,   X1,  X2, Y2};
        tbl[2] = '{2, 1'b1, H0,   X1,  X2, Y2};
        tbl[3] = '{1, 1'b0, '0,   X1,  '0, '0};
        tbl[4] = '{3, 1'b0, ONE,  X1,  '0, X1};
        tbl[5] = '{1, 1'b0, H0,   '0,  '0, '0};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_o_valid", 128'(o_valid), 128'(0));
        chk("reset_o_busy", 128'(o_busy), 128'(0));
        chk("reset_o_data_y", o_data_y, 128'(0));

        // Directed message table
        foreach (tbl[i]) begin
            load_key(tbl[i].ctx, tbl[i].h);
            obs_q.delete();
            send(tbl[i].ctx, 1'b1, !tbl[i].two, tbl[i].x1, tbl[i].h, e0);
            if (tbl[i].two) send(tbl[i].ctx, 1'b0, 1'b1, tbl[i].x2, tbl[i].h, e0);
            idle(0);
            wait_obs(1);
            if (obs_q.size() > 0) begin
                chk("tbl_y", obs_q[0].y, tbl[i].y);
                chk("tbl_ctx", 128'(obs_q[0].ctx), 128'(tbl[i].ctx));
                chk("tbl_latency", 128'(obs_q[0].due - e0), 128'(L));
            end
            idle(2);
        end

        // Four interleaved two-block messages at full rate
        for (int c = 0; c < N_CTX; c++) load_key(c, H0);
        obs_q.delete();
        for (int b = 0; b < 8; b++)
            send(b % 4, b < 4, b >= 4, (b < 4) ? X1 : X2, H0, ea[b]);
        idle(0);
        for (int b = 1; b < 8; b++) chk("ilv_no_stall", 128'(ea[b] - ea[0]), 128'(b));
        wait_obs(4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            chk("ilv_ctx", 128'(obs_q[k].ctx), 128'(k));
            chk("ilv_y", obs_q[k].y, Y2);
            chk("ilv_edge", 128'(obs_q[k].due - obs_q[0].due), 128'(k));
        end
        idle(2);

        // Back-to-back beats on one context stall for MULT_LAT cycles
        obs_q.delete();
        send(1, 1'b1, 1'b0, X1, H0, e0);
        send(1, 1'b0, 1'b1, X2, H0, e1);
        idle(0);
        chk("stall_gap", 128'(e1 - e0), 128'(L + 1));
        wait_obs(1);
        if (obs_q.size() > 0) chk("stall_y", obs_q[0].y, Y2);
        idle(2);

        // Asynchronous reset with three beats in flight
        obs_q.delete();
        for (int c = 0; c < 3; c++) send(c, 1'b1, 1'b1, X1, H0, e0);
        i_valid = 1'b0;
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(8);
        chk("rst_no_result", 128'(obs_q.size()), 128'(0));
        chk("rst_busy_clear", 128'(o_busy), 128'(0));
        load_key(0, H0);
        send(0, 1'b1, 1'b1, X1, H0, e0);
        idle(0);
        wait_obs(1);
        if (obs_q.size() > 0) chk("post_rst_y", obs_q[0].y, Y1);
        idle(2);

`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
        // Per-context keys: shared i_h_key is ignored for beats
        load_key(2, H0);
        load_key(3, '0);
        obs_q.delete();
        send(2, 1'b1, 1'b1, X1, 128'h1234, e0);
        send(3, 1'b1, 1'b1, X1, H0, e0);
        idle(0);
        wait_obs(2);
        if (obs_q.size() > 1) begin
            chk("key_ctx2_y", obs_q[0].y, Y1);
            chk("key_ctx3_y", obs_q[1].y, '0);
        end
        idle(2);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_ctx    = ctx_id_t'($urandom_range(0, N_CTX - 1));
            i_sop    = ($urandom_range(0, 3) == 0);
            i_eop    = ($urandom_range(0, 2) == 0);
            i_data_x = {$urandom(), $urandom(), $urandom(), $urandom()};
            i_h_key  = ($urandom_range(0, 1) != 0) ? H0 : {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
            i_key_load = ($urandom_range(0, 7) == 0);
            i_key_ctx  = ctx_id_t'($urandom_range(0, N_CTX - 1));
`endif
            @(posedge clk);
            #1;
        end
`ifdef GHASH_CORE_MCTX_KEY_PER_CTX_EN
        i_key_load = 1'b0;
`endif
        idle(L + 4);
        chk("rand_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
